uart_rx: RTL and testbench
==========================

# uart_rx

Serial-to-parallel UART receiver for the DE10 UART design; consumes the asynchronous `rx` line that the UART transmit path drives and presents received bytes to fabric logic. It synchronises the line, detects and qualifies start bits, and samples 8N1 frames at bit centre. Each good byte goes into a one-entry holding register with a valid/ready handshake. Framing and overrun errors are flagged.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s. `CLKS_PER_BIT = CLK_FREQ/BAUD` (truncating), and `HALF_BIT = CLKS_PER_BIT/2`. `CLKS_PER_BIT` must be ≥ 8.

- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial input. Idles high.
- `rx_data` out 8: received byte. Valid while `rx_valid` is high.
- `rx_valid` out 1: holding register is full.
- `rx_ready` in 1: consumer accepts the byte. A transfer occurs on any clock edge where `rx_valid` and `rx_ready` are both high.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a completed byte is dropped because the holding register is full.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Synchroniser:** `rx` passes through a 2-FF synchroniser (`rx_s`). Both flops reset to 1.
- **FSM states:** IDLE, START, DATA, PARITY (only when the parity macro is defined), STOP, WAIT_HIGH.
- **IDLE:** when `rx_s`==0, clear the bit counter and go to START.
- **START:** at count `HALF_BIT-1`:
  - if `rx_s`==0, go to DATA with the counter cleared;
  - otherwise treat it as a glitch and return to IDLE with no outputs.
- **DATA:** sample `rx_s` at every count `CLKS_PER_BIT-1`. Bits arrive LSB first into a shift register. After bit 7, go to PARITY or STOP.
- **STOP:** sample at count `CLKS_PER_BIT-1`.
  - 1 → byte complete; go to IDLE on the next cycle. This allows back-to-back frames, because the next start edge falls at least half a bit later.
  - 0 → pulse `frame_err`, discard the byte, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s`==1, then go to IDLE. This covers break conditions.
- **Byte complete:**
  - If `rx_valid`==0, or a handshake occurs in the same cycle, load `rx_data` and set `rx_valid`.
  - Otherwise keep the old byte and pulse `overrun`.
- `rx_valid` clears on a handshake unless a new byte loads in that same cycle.
- **Reset at any time:** FSM → IDLE, counters cleared. Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0. Any frame in flight is abandoned. If the line is low at reset release, a new frame starts on the next low sample (behaviour equals IDLE with `rx_s`==0).

## Timing
- `rx` to `rx_s` latency: 2 clocks.
- Bit-centre sample points, counted from the first cycle `rx_s` is low: `HALF_BIT` + n·`CLKS_PER_BIT`.
- `rx_valid` rises 1 clock after the stop-bit sample edge.
- `frame_err` and `overrun` are asserted for exactly one clock, on the cycle after the stop sample.
- `rx_data` holds stable while `rx_valid` is high and there is no handshake.
- Throughput: one byte per frame time (10 bits, or 11 with parity). No gaps between frames are required.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - Frame is 8E1. The PARITY state samples a ninth bit at `CLKS_PER_BIT-1`.
  - An added output `parity_err` (1 bit, reset 0) pulses for one clock alongside byte completion when the XOR of the data bits and the parity bit is 1.
  - The byte is still loaded when parity fails.
- **Undefined:** frame is 8N1, the PARITY state is absent, and there is no `parity_err` port.

## Test plan
All scenarios use `CLK_FREQ`=100_000_000, `BAUD`=1_000_000 (`CLKS_PER_BIT`=100, 10 ns clock).
- **Single byte:** pulse `reset` for 2 cycles, hold `rx_ready`=1, send 0x55 8N1 → `rx_valid` for 1 cycle with `rx_data`=0x55; no `frame_err`, no `overrun`.
- **Back-to-back:** send 0xA5 then 0x3C with zero idle between frames, `rx_ready`=1 → two valid pulses in order, 0xA5 then 0x3C, ~1000 clocks apart.
- **Glitch rejection:** drive `rx` low for 30 clocks, then high → `busy` pulses, but no `rx_valid` and no `frame_err`.
- **Framing error:** send 0xF0 with the stop bit 0, then hold the line low for 2 bit times → one `frame_err` pulse, no `rx_valid`, and `busy` stays high until the line returns high.
- **Overrun:** hold `rx_ready`=0 and send 0x11, then 0x22 → `rx_data`=0x11 held with `rx_valid`=1, and one `overrun` pulse at the end of the second frame. Then raise `rx_ready` for 1 cycle → `rx_valid` goes to 0.
- **Reset mid-frame:** assert `reset` during bit 4 of 0x81, then send 0x7E → only 0x7E is received. With `UART_RX_PARITY_EN`, sending 0x07 with parity bit 0 gives `parity_err`=1 and `rx_data`=0x07.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a two-flop input synchroniser, bit-centre
// sampling, a one-entry holding register with valid/ready handshake, and
// one-cycle framing-error and overrun pulses.
// Optional feature macro: UART_RX_PARITY_EN switches the frame to 8E1 and
// adds the parity_err output. Without the macro the frame is 8N1.

module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_rx_meta;
  logic             r_rx_s;
  logic             r_busy;
  logic             r_frame_err;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_overrun;
`ifdef UART_RX_PARITY_EN
  logic             r_par_bit;
  logic             r_parity_err;
`endif

  logic w_half_done;
  logic w_bit_done;
  logic w_byte_done;
  logic w_handshake;

  assign w_half_done = (r_cnt == CNT_HALF_LAST);
  assign w_bit_done  = (r_cnt == CNT_BIT_LAST);
  // A byte completes on the stop-bit sample edge when the stop bit is high.
  assign w_byte_done = (r_state == S_STOP) && w_bit_done && r_rx_s;
  assign w_handshake = r_rx_valid && rx_ready;

  // Two-flop synchroniser; idles high so a reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking so each flop takes its input's pre-edge value;
      // blocking here would collapse the chain into a single stage.
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Receive FSM: start qualification, bit-centre sampling, stop check.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!r_rx_s) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (w_half_done) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
            end else begin
              // Line went back high before mid-start: a glitch, not a frame.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_bit_done) begin
            r_cnt     <= '0;
            r_par_bit <= r_rx_s;
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (w_bit_done) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= ^{r_shift, r_par_bit};
`endif
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_WAIT_HIGH: begin
          // Break or stuck-low line: hold off until it returns to idle.
          if (r_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: load completed bytes, clear on handshake, flag overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the holding register is reset because rx_data has a defined
      // reset value on the port; the shift register behind it need not be.
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_byte_done) begin
        if (!r_rx_valid || w_handshake) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_handshake) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = r_busy;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 100 MHz / 1 Mbaud (100 clocks per
// bit). Inputs change on the falling edge; a monitor samples 1 ns after each
// falling edge and records transfers and pulse counts for the checks.

module tb_uart_rx;

  localparam int CPB = 100;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_LAT    = 1053;
  localparam int FRAME_CLKS  = 1100;
`else
  localparam int STOP_LAT    = 953;
  localparam int FRAME_CLKS  = 1000;
`endif

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ(100_000_000),
    .BAUD    (1_000_000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy     (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  // Monitor state
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         fe_cnt   = 0;
  int         ov_cnt   = 0;
  int         busy_cnt = 0;
  int         pe_cnt   = 0;

  always @(negedge clk) begin
    #1;
    if (rx_valid && rx_ready) begin
      got_q.push_back(rx_data);
      got_cyc.push_back(cyc);
    end
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
    if (busy)      busy_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
  end

  // Snapshot of monitor counts at the start of each scenario
  int b_got, b_fe, b_ov, b_busy, b_pe;
  int t_start;

  task automatic snap();
    b_got  = got_q.size();
    b_fe   = fe_cnt;
    b_ov   = ov_cnt;
    b_busy = busy_cnt;
    b_pe   = pe_cnt;
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 8'hxx;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < got_cyc.size()) return got_cyc[i];
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Whole frame, LSB first; called on a falling edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop_bit);
  endtask

  initial begin
    // Reset: two cycles
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_rx_data",   32'(rx_data),   32'h00);
    check("reset_rx_valid",  32'(rx_valid),  32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun",   32'(overrun),   32'h0);
    check("reset_busy",      32'(busy),      32'h0);
`ifdef UART_RX_PARITY_EN
    check("reset_parity_err", 32'(parity_err), 32'h0);
`endif
    @(negedge clk);
    rx_ready = 1'b1;
    repeat (20) @(negedge clk);

    // Single byte 0x55
    snap();
    send_frame(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    check("single_count",   32'(got_q.size() - b_got),       32'd1);
    check("single_data",    32'(got_at(b_got)),              32'h55);
    check("single_latency", 32'(cyc_at(b_got) - t_start),    32'(STOP_LAT));
    check("single_fe",      32'(fe_cnt - b_fe),              32'd0);
    check("single_ov",      32'(ov_cnt - b_ov),              32'd0);
    check("single_busy",    32'(busy),                       32'h0);

    // Back-to-back 0xA5, 0x3C with no idle gap
    snap();
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_count",   32'(got_q.size() - b_got),                    32'd2);
    check("b2b_first",   32'(got_at(b_got)),                           32'hA5);
    check("b2b_second",  32'(got_at(b_got + 1)),                       32'h3C);
    check("b2b_spacing", 32'(cyc_at(b_got + 1) - cyc_at(b_got)),       32'(FRAME_CLKS));
    check("b2b_fe",      32'(fe_cnt - b_fe),                           32'd0);

    // Glitch: 30 clocks low, rejected at mid-start
    repeat (50) @(negedge clk);
    snap();
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_busy_cycles", 32'(busy_cnt - b_busy),    32'd50);
    check("glitch_count",       32'(got_q.size() - b_got), 32'd0);
    check("glitch_fe",          32'(fe_cnt - b_fe),        32'd0);

    // Framing error: 0xF0 with low stop bit, then line low for 2 bit times
    repeat (50) @(negedge clk);
    snap();
    send_frame(8'hF0, 1'b0);
    rx = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check("frame_fe_pulse",  32'(fe_cnt - b_fe),        32'd1);
    check("frame_count",     32'(got_q.size() - b_got), 32'd0);
    check("frame_busy_low",  32'(busy),                 32'h1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("frame_busy_released", 32'(busy), 32'h0);
    repeat (100) @(negedge clk);

    // Overrun: consumer stalled, two bytes arrive
    rx_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (20) @(negedge clk);
    check("ovr_valid_held", 32'(rx_valid),              32'h1);
    check("ovr_data_held",  32'(rx_data),               32'h11);
    check("ovr_pulse",      32'(ov_cnt - b_ov),         32'd1);
    check("ovr_no_xfer",    32'(got_q.size() - b_got),  32'd0);
    check("ovr_fe",         32'(fe_cnt - b_fe),         32'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    #1;
    check("ovr_drain_count", 32'(got_q.size() - b_got), 32'd1);
    check("ovr_drain_data",  32'(got_at(b_got)),        32'h11);
    check("ovr_valid_clear", 32'(rx_valid),             32'h0);
    @(negedge clk);

    // Reset during bit 4 of 0x81, then 0x7E
    rx_ready = 1'b1;
    repeat (50) @(negedge clk);
    snap();
    drive_bit(1'b0);            // start
    drive_bit(1'b1);            // bit 0
    drive_bit(1'b0);            // bit 1
    drive_bit(1'b0);            // bit 2
    drive_bit(1'b0);            // bit 3
    rx = 1'b0;                  // first half of bit 4
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_busy",  32'(busy),     32'h0);
    check("midrst_valid", 32'(rx_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rx    = 1'b1;
    repeat (300) @(negedge clk);
    check("midrst_abandoned", 32'(got_q.size() - b_got), 32'd0);
    send_frame(8'h7E, 1'b1);
    repeat (20) @(negedge clk);
    check("midrst_count", 32'(got_q.size() - b_got), 32'd1);
    check("midrst_data",  32'(got_at(b_got)),        32'h7E);
    check("midrst_fe",    32'(fe_cnt - b_fe),        32'd0);

`ifdef UART_RX_PARITY_EN
    // Parity: 0x07 with parity bit 0 is wrong for even parity
    repeat (50) @(negedge clk);
    snap();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    repeat (20) @(negedge clk);
    check("par_bad_pulse", 32'(pe_cnt - b_pe),        32'd1);
    check("par_bad_count", 32'(got_q.size() - b_got), 32'd1);
    check("par_bad_data",  32'(got_at(b_got)),        32'h07);
    snap();
    send_frame(8'h07, 1'b1);
    repeat (20) @(negedge clk);
    check("par_good_pulse", 32'(pe_cnt - b_pe),       32'd0);
    check("par_good_data",  32'(got_at(b_got)),       32'h07);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
